// File: rtl/serial_sub_16b_if.sv
// Operand/result handshake bundle for the bit-serial 16-bit subtractor.
// The master drives operands and out_ready. The slave returns in_ready, the result and the flags.
interface serial_sub_16b_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] A;
  logic [15:0] B;
  logic        Bin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] Diff;
  logic        Bout;
  logic        Z;
  logic        N;
  logic        V;

  modport master (
    output in_valid, A, B, Bin, out_ready,
    input  in_ready, out_valid, Diff, Bout, Z, N, V
  );

  modport slave (
    input  in_valid, A, B, Bin, out_ready,
    output in_ready, out_valid, Diff, Bout, Z, N, V
  );
endinterface

// File: rtl/serial_sub_16b.sv
// Bit-serial A - B - Bin, LSB first. Latency is 16 cycles from accept to out_valid.
// A result is held in DONE until out_ready is seen. No new operand is taken until that handshake completes.
module serial_sub_16b (
  input  logic             clk,
  input  logic             rst_n,
  serial_sub_16b_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [15:0] diff;
    logic        bout;
    logic        z;
    logic        n;
    logic        v;
  } res_t;

  state_t      state;
  state_t      state_nxt;

  logic [15:0] a_reg;
  logic [15:0] b_reg;
  logic [15:0] sh_reg;
  logic        br;
  logic [3:0]  cnt;

  logic        accept;
  logic        step;
  logic        last;

  logic        a_bit;
  logic        b_bit;
  logic        d_bit;
  logic        br_nxt;

  res_t        res_d;
  res_t        res_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid)  state_nxt = CALC;
      CALC:    if (cnt == 4'd15)  state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  // Output and control decode
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    accept        = 1'b0;
    step          = 1'b0;
    last          = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        accept       = bus.in_valid;
      end
      CALC: begin
        step = 1'b1;
        last = (cnt == 4'd15);
      end
      DONE: begin
        bus.out_valid = 1'b1;
      end
      default: ;
    endcase
  end

  // One-bit full subtractor on the bit selected by the counter
  always_comb begin
    a_bit  = a_reg[cnt];
    b_bit  = b_reg[cnt];
    d_bit  = a_bit ^ b_bit ^ br;
    br_nxt = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br);
  end

  always_comb begin
    res_d.diff = {d_bit, sh_reg[15:1]};
    res_d.bout = br_nxt;
    res_d.z    = ({d_bit, sh_reg[15:1]} == 16'h0000);
    res_d.n    = d_bit;
    res_d.v    = (a_reg[15] != b_reg[15]) && (d_bit != a_reg[15]);
  end

  // Operands stay unshifted so the sign bits remain available for V on the last step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg  <= 16'h0000;
      b_reg  <= 16'h0000;
      sh_reg <= 16'h0000;
      br     <= 1'b0;
      cnt    <= 4'd0;
    end else if (accept) begin
      a_reg <= bus.A;
      b_reg <= bus.B;
      br    <= bus.Bin;
      cnt   <= 4'd0;
    end else if (step) begin
      sh_reg <= {d_bit, sh_reg[15:1]};
      br     <= br_nxt;
      if (!last) begin
        cnt <= cnt + 4'd1;
      end
    end
  end

  // Result register only loads on the final step, so it holds through IDLE and CALC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= '0;
    end else if (last) begin
      res_q <= res_d;
    end
  end

  assign bus.Diff = res_q.diff;
  assign bus.Bout = res_q.bout;
  assign bus.Z    = res_q.z;
  assign bus.N    = res_q.n;
  assign bus.V    = res_q.v;

endmodule

// File: tb/tb_serial_sub_16b.sv
// Scoreboarded bench for serial_sub_16b: golden results are queued at accept and compared at out_valid.
module tb_serial_sub_16b;

  typedef struct packed {
    logic [15:0] diff;
    logic        bout;
    logic        z;
    logic        n;
    logic        v;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errs;
  exp_t sb[$];
  logic [15:0] prev_diff;

  serial_sub_16b_if bus ();

  serial_sub_16b dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic bin);
    logic [16:0] t;
    exp_t e;
    t      = {1'b0, a} - {1'b0, b} - {16'd0, bin};
    e.diff = t[15:0];
    e.bout = t[16];
    e.z    = (t[15:0] == 16'h0000);
    e.n    = t[15];
    e.v    = (a[15] != b[15]) && (t[15] != a[15]);
    return e;
  endfunction

  // Called at a negedge; returns at the negedge right after the result handshake.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic bin, input int stall);
    int   t;
    int   k;
    exp_t e;
    bus.A        = a;
    bus.B        = b;
    bus.Bin      = bin;
    bus.in_valid = 1'b1;
    t = 0;
    while (!bus.in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) begin
      check("in_ready_timeout", 16'(bus.in_ready), 16'd1);
      bus.in_valid = 1'b0;
      return;
    end
    sb.push_back(model(a, b, bin));
    @(negedge clk);
    check("accept_in_ready", 16'(bus.in_ready), 16'd0);
    bus.in_valid = 1'b0;
    bus.A        = 16'($urandom);
    bus.B        = 16'($urandom);
    bus.Bin      = 1'($urandom);
    check("diff_hold_calc", bus.Diff, prev_diff);
    k = 0;
    while (!bus.out_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("latency", 16'(k), 16'd16);
    if (sb.size() == 0) begin
      check("sb_empty", 16'(sb.size()), 16'd1);
      return;
    end
    e = sb.pop_front();
    check("diff", bus.Diff, e.diff);
    check("bout", 16'(bus.Bout), 16'(e.bout));
    check("z",    16'(bus.Z),    16'(e.z));
    check("n",    16'(bus.N),    16'(e.n));
    check("v",    16'(bus.V),    16'(e.v));
    for (int i = 0; i < stall; i++) begin
      bus.in_valid = 1'b1;
      bus.A        = 16'($urandom);
      bus.B        = 16'($urandom);
      @(negedge clk);
      check("stall_diff",      bus.Diff,              e.diff);
      check("stall_flags",     16'({bus.Bout, bus.Z, bus.N, bus.V}),
                               16'({e.bout, e.z, e.n, e.v}));
      check("stall_out_valid", 16'(bus.out_valid),    16'd1);
      check("stall_in_ready",  16'(bus.in_ready),     16'd0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("post_hs_out_valid", 16'(bus.out_valid), 16'd0);
    check("post_hs_in_ready",  16'(bus.in_ready),  16'd1);
    prev_diff = e.diff;
  endtask

  initial begin
    n_checks      = 0;
    n_errs        = 0;
    prev_diff     = 16'h0000;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.A         = 16'h0000;
    bus.B         = 16'h0000;
    bus.Bin       = 1'b0;
    bus.out_ready = 1'b0;

    @(negedge clk);
    check("rst_diff",      bus.Diff,              16'h0000);
    check("rst_flags",     16'({bus.Bout, bus.Z, bus.N, bus.V}), 16'd0);
    check("rst_out_valid", 16'(bus.out_valid),    16'd0);
    check("rst_in_ready",  16'(bus.in_ready),     16'd1);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(16'h0005, 16'h0003, 1'b0, 0);
    run_op(16'h0003, 16'h0005, 1'b0, 0);
    run_op(16'h8000, 16'h0001, 1'b0, 0);
    run_op(16'h1234, 16'h1233, 1'b1, 0);
    run_op(16'h0000, 16'h0000, 1'b1, 5);
    run_op(16'hABCD, 16'h1234, 1'b0, 0);
    run_op(16'h7FFF, 16'hFFFF, 1'b0, 0);
    for (int i = 0; i < 6; i++) begin
      run_op(16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
    end
    run_op(16'h0000, 16'h0001, 1'b0, 0);

    // Abort mid-operation: reset lands while the counter reads 8
    bus.A        = 16'h4444;
    bus.B        = 16'h1111;
    bus.Bin      = 1'b0;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_out_valid", 16'(bus.out_valid), 16'd0);
    check("abort_diff",      bus.Diff,           16'h0000);
    check("abort_in_ready",  16'(bus.in_ready),  16'd1);
    check("abort_bout",      16'(bus.Bout),      16'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    prev_diff = 16'h0000;
    @(negedge clk);
    run_op(16'h0010, 16'h0001, 1'b0, 0);

    check("sb_drained", 16'(sb.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/serial_sub_16b.md
SERIAL_SUB_16B -- requirements
Module: serial_sub_16b

Interface
REQ-001: Port clk, input, 1 bit; single clock, all state updates on its rising edge.
REQ-002: Port rst_n, input, 1 bit; reset is asynchronous and active-low.
REQ-003: Port in_valid, input, 1 bit; operand set present on A, B, Bin.
REQ-004: Port in_ready, output, 1 bit; block can accept an operand set.
REQ-005: Port A, input, 16 bits; minuend.
REQ-006: Port B, input, 16 bits; subtrahend.
REQ-007: Port Bin, input, 1 bit; borrow-in.
REQ-008: Port out_valid, output, 1 bit; result and flags valid.
REQ-009: Port out_ready, input, 1 bit; consumer accepts the result.
REQ-010: Port Diff, output, 16 bits; A - B - Bin, modulo 2^16.
REQ-011: Port Bout, output, 1 bit; final borrow, 1 when unsigned A < B + Bin.
REQ-012: Ports Z, N, V, outputs, 1 bit each; zero, negative and signed-overflow flags of Diff.

Function
REQ-013: FSM SHALL have three states: IDLE, CALC and DONE.
REQ-014: in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-015: Accept SHALL occur on an edge where state is IDLE and in_valid=1; on that edge A, B and Bin are latched into internal registers, the bit counter is cleared to 0, and state goes to CALC.
REQ-016: Each CALC edge SHALL process one bit, LSB first, through a one-bit full subtractor:
  - d = a^b^br
  - br_next = (~a&b) | (~(a^b)&br)
  - d is shifted into the result register; the counter increments.
REQ-017: The edge that processes bit 15 (counter=15) SHALL move to DONE with Diff, Bout and the flags registered.
REQ-018: Latency SHALL be exactly 16 CALC edges, so out_valid is first high in the 16th cycle after the accept edge.
REQ-019: Flags SHALL be defined as:
  - Z = (Diff == 0)
  - N = Diff[15]
  - V = (A[15] != B[15]) && (Diff[15] != A[15]), using the latched A and B.
REQ-020: In DONE, Diff, Bout, Z, N and V SHALL hold stable until the edge where out_ready=1; that edge returns the FSM to IDLE.
REQ-021: in_valid SHALL be ignored in CALC and DONE; no accept occurs in the same cycle as the out_valid/out_ready handshake.
REQ-022: Changes on A, B or Bin after accept SHALL NOT affect the result in progress.
REQ-023: Outputs SHALL be registered; Diff and the flags SHALL hold their last values in IDLE and CALC until overwritten on entry to DONE.
REQ-024: Counter SHALL be 4 bits and SHALL NOT wrap within a single operation.

Reset
REQ-025: rst_n=0 SHALL immediately force:
  - state = IDLE, counter = 0
  - internal operand and borrow registers = 0
  - Diff = 0x0000; Bout, Z, N, V, out_valid = 0
  - in_ready = 1
REQ-026: Reset asserted during CALC or DONE SHALL abort the operation with no result presented; the first accept after rst_n returns to 1 SHALL behave as after power-up.

Verification
REQ-027: A=0x0005, B=0x0003, Bin=0 -> Diff=0x0002, Bout=0, Z=0, N=0, V=0; out_valid first high 16 cycles after accept.
REQ-028: A=0x0003, B=0x0005, Bin=0 -> Diff=0xFFFE, Bout=1, N=1, Z=0, V=0.
REQ-029: A=0x8000, B=0x0001, Bin=0 -> Diff=0x7FFF, Bout=0, N=0, V=1.
REQ-030: A=0x1234, B=0x1233, Bin=1 -> Diff=0x0000, Z=1, Bout=0, V=0; A=0x0000, B=0x0000, Bin=1 -> Diff=0xFFFF, Bout=1, N=1.
REQ-031: Back-pressure: out_ready=0 for 5 cycles in DONE with in_valid=1 and new operands -> Diff and flags unchanged, in_ready=0, no new accept; out_ready=1 -> IDLE next cycle, in_ready=1, then the new operands are accepted.
REQ-032: rst_n pulsed low at CALC counter=8 -> out_valid=0, Diff=0x0000, in_ready=1 immediately; a subsequent A=0x0010, B=0x0001 -> Diff=0x000F after 16 cycles.
